// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment scan receiver
//
// Purpose: glyph table, blank pattern, segment bit order and digit record
//          shared by seg7_glyph_dec and seg7_scan_rx.
// Ports:   none (package).
package seg7_pkg;

  // Segment bit order within a 7-bit pattern (active-low on the bus).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low glyphs, written g..a (MSB first), indexed by nibble value.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  // One decoded digit.
  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } digit_t;

endpackage

// File: rtl/seg7_glyph_dec.sv
// rtl/seg7_glyph_dec.sv - combinational active-low segment pattern to nibble decoder
//
// Purpose: map one 7-bit active-low segment pattern to a hex nibble, flagging
//          the all-dark pattern as blank and anything unrecognised as err.
// Ports:
//   i_seg_n   in  7  active-low segments, bit0=a .. bit6=g
//   o_nibble  out 4  decoded value (0 when blank or err)
//   o_blank   out 1  pattern was all dark
//   o_err     out 1  pattern is not a legal hex glyph
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_nibble = 4'h0;
    o_blank  = 1'b0;
    o_err    = 1'b1;
    if (i_seg_n == SEG_BLANK) begin
      o_blank = 1'b1;
      o_err   = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (i_seg_n == GLYPH[k]) begin
          o_nibble = 4'(k);
          o_err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// rtl/seg7_scan_rx.sv - 7-segment scan bus receiver with stability filter and frame handshake
//
// Purpose: watch a multiplexed active-low anode/segment bus, capture each digit
//          once its pattern has been steady for STABLE cycles, assemble NDIG
//          digits into a frame and offer it through a valid/ready handshake.
// Ports:
//   i_clk          in  1       system clock
//   i_rst_n        in  1       asynchronous active-low reset
//   i_an_n         in  NDIG    active-low one-hot digit select
//   i_seg_n        in  7       active-low segments, bit0=a .. bit6=g
//   i_frame_ready  in  1       consumer accepts the held frame
//   o_digits       out 4*NDIG  decoded nibbles, digit i at [4i+3:4i]
//   o_blank        out NDIG    digit i was all dark
//   o_err          out NDIG    digit i was not a legal glyph
//   o_overrun      out 1       a complete frame was dropped while holding
//   o_frame_valid  out 1       outputs hold a complete frame
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NDIG-1:0]   i_an_n,
  input  logic [6:0]        i_seg_n,
  input  logic              i_frame_ready,
  output logic [4*NDIG-1:0] o_digits,
  output logic [NDIG-1:0]   o_blank,
  output logic [NDIG-1:0]   o_err,
  output logic              o_overrun,
  output logic              o_frame_valid
);

  localparam int RW = $clog2(STABLE + 1);
  localparam logic [NDIG-1:0] ONE = NDIG'(1);

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [NDIG+6:0]     r_prev;
  logic [RW-1:0]       r_run;
  logic [NDIG-1:0]     r_seen;
  logic [4*NDIG-1:0]   r_sh_nib;
  logic [NDIG-1:0]     r_sh_blank;
  logic [NDIG-1:0]     r_sh_err;
  logic [4*NDIG-1:0]   r_digits;
  logic [NDIG-1:0]     r_blank;
  logic [NDIG-1:0]     r_err;
  logic                r_overrun;
  logic                r_valid;

  logic [NDIG-1:0]     w_sel;
  logic                w_legal;
  logic                w_same;
  logic                w_cap;
  logic [NDIG-1:0]     w_cap_vec;
  logic                w_full;
  logic [3:0]          w_nib;
  logic                w_blank;
  logic                w_err;
  logic                w_load;
  logic                w_seen_clr;
  logic                w_ovr_set;
  logic                w_ack;

  seg7_glyph_dec u_dec (
    .i_seg_n  (i_seg_n),
    .o_nibble (w_nib),
    .o_blank  (w_blank),
    .o_err    (w_err)
  );

  // Exactly one anode low: nonzero and no second bit set.
  assign w_sel   = ~i_an_n;
  assign w_legal = (w_sel != '0) && ((w_sel & (w_sel - ONE)) == '0);
  assign w_same  = ({i_an_n, i_seg_n} == r_prev);

  // The edge on which the run climbs from STABLE-1 to STABLE is the single
  // capture point of a run; once saturated no further capture happens.
  assign w_cap     = w_legal && w_same && (r_run == RW'(STABLE - 1));
  assign w_cap_vec = w_cap ? w_sel : '0;
  assign w_full    = &r_seen;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_seen_clr = 1'b0;
    w_ovr_set  = 1'b0;
    w_ack      = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_full) begin
          w_load     = 1'b1;
          w_seen_clr = 1'b1;
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        // frame_valid is always high here, so ready alone is the handshake.
        // A fill coinciding with the handshake is dropped.
        if (i_frame_ready) begin
          w_ack      = 1'b1;
          w_seen_clr = w_full;
          w_state_nx = S_COLLECT;
        end else if (w_full) begin
          w_ovr_set  = 1'b1;
          w_seen_clr = 1'b1;
        end
      end
      default: w_state_nx = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev     <= '0;
      r_run      <= '0;
      r_seen     <= '0;
      r_sh_nib   <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
      r_digits   <= '0;
      r_blank    <= '0;
      r_err      <= '0;
      r_overrun  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_prev <= {i_an_n, i_seg_n};

      if (!w_legal) begin
        r_run <= '0;
      end else if (!w_same) begin
        r_run <= RW'(1);
      end else if (r_run < RW'(STABLE)) begin
        r_run <= r_run + RW'(1);
      end

      for (int k = 0; k < NDIG; k++) begin
        if (w_cap_vec[k]) begin
          r_sh_nib[4*k +: 4] <= w_nib;
          r_sh_blank[k]      <= w_blank;
          r_sh_err[k]        <= w_err;
        end
      end

      // A capture on a clearing edge still marks its own digit as seen.
      r_seen <= (w_seen_clr ? '0 : r_seen) | w_cap_vec;

      if (w_load) begin
        r_digits <= r_sh_nib;
        r_blank  <= r_sh_blank;
        r_err    <= r_sh_err;
        r_valid  <= 1'b1;
      end
      if (w_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_digits      = r_digits;
  assign o_blank       = r_blank;
  assign o_err         = r_err;
  assign o_overrun     = r_overrun;
  assign o_frame_valid = r_valid;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb/tb_seg7_scan_rx.sv - scoreboard testbench for seg7_scan_rx
module tb_seg7_scan_rx;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
    logic        o;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_ready;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [7:0]  err;
  logic        overrun;
  logic        frame_valid;

  int          n_assert = 0;
  int          n_fail   = 0;
  frame_t      sb [$];
  logic [6:0]  glyph [16];

  seg7_scan_rx #(.NDIG(8), .STABLE(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_an_n        (an_n),
    .i_seg_n       (seg_n),
    .i_frame_ready (frame_ready),
    .o_digits      (digits),
    .o_blank       (blank),
    .o_err         (err),
    .o_overrun     (overrun),
    .o_frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int d, input logic [6:0] seg, input int cyc);
    an_n  = ~(8'b1 << d);
    seg_n = seg;
    step(cyc);
  endtask

  task automatic idle(input int cyc);
    an_n  = 8'hFF;
    seg_n = 7'h7F;
    step(cyc);
  endtask

  // Scan all eight digits with nibble values from nibs; short_dig (if 0..7)
  // is held only three cycles.
  task automatic scan(input logic [31:0] nibs, input int short_dig);
    for (int d = 0; d < 8; d++)
      strobe(d, glyph[nibs[4*d +: 4]], (d == short_dig) ? 3 : 4);
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] b, input logic [7:0] e, input logic o);
    frame_t f;
    f.d = d; f.b = b; f.e = e; f.o = o;
    sb.push_back(f);
  endtask

  // Every accepted frame must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
      frame_t f;
      check("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        f = sb.pop_front();
        check("digits", digits, f.d);
        check("blank", 32'(blank), 32'(f.b));
        check("err", 32'(err), 32'(f.e));
        check("overrun", 32'(overrun), 32'(f.o));
      end
    end
  end

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst_n       = 1'b0;
    an_n        = 8'hFF;
    seg_n       = 7'h7F;
    frame_ready = 1'b1;
    step(3);
    check("rst_digits", digits, 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    idle(6);
    check("idle_valid", 32'(frame_valid), 32'h0);

    // Basic scan, glyphs 1..8.
    push(32'h87654321, 8'h00, 8'h00, 1'b0);
    scan(32'h87654321, -1);
    idle(3);
    check("basic_drained", 32'(sb.size()), 32'd0);
    check("basic_valid_low", 32'(frame_valid), 32'h0);

    // Reset mid-scan: partial frame must be discarded.
    for (int d = 0; d < 4; d++) strobe(d, glyph[d], 4);
    strobe(4, glyph[4], 2);
    rst_n = 1'b0;
    #2;
    check("midrst_digits", digits, 32'h0);
    check("midrst_valid", 32'(frame_valid), 32'h0);
    step(2);
    rst_n = 1'b1;
    idle(4);
    for (int d = 4; d < 8; d++) strobe(d, glyph[d], 4);
    idle(5);
    check("partial_discard", 32'(frame_valid), 32'h0);

    // Glitch filter: digit 2 held only three cycles.
    scan(32'h0FEDCBA9, 2);
    idle(5);
    check("short_no_frame", 32'(frame_valid), 32'h0);
    push(32'h0FEDCBA9, 8'h00, 8'h00, 1'b0);
    strobe(2, glyph[4'hB], 4);
    idle(3);
    check("restrobe_drained", 32'(sb.size()), 32'd0);

    // Blank and illegal patterns.
    push(32'h76040210, 8'h08, 8'h20, 1'b0);
    for (int d = 0; d < 8; d++)
      strobe(d, (d == 3) ? 7'h7F : (d == 5) ? 7'b0101010 : glyph[d], 4);
    idle(3);
    check("blankerr_drained", 32'(sb.size()), 32'd0);

    // Backpressure and overrun.
    frame_ready = 1'b0;
    push(32'h87654321, 8'h00, 8'h00, 1'b1);
    scan(32'h87654321, -1);
    idle(2);
    check("bp_valid", 32'(frame_valid), 32'h1);
    check("bp_no_overrun", 32'(overrun), 32'h0);
    scan(32'h00000000, -1);
    idle(2);
    check("bp_overrun", 32'(overrun), 32'h1);
    check("bp_frozen", digits, 32'h87654321);
    frame_ready = 1'b1;
    step(1);
    check("bp_valid_clr", 32'(frame_valid), 32'h0);
    check("bp_overrun_clr", 32'(overrun), 32'h0);
    check("bp_drained", 32'(sb.size()), 32'd0);
    idle(3);

    // Two-hot select never captures.
    strobe(0, glyph[5], 0);
    an_n = 8'hFC;
    step(10);
    for (int d = 1; d < 8; d++) strobe(d, glyph[d], 4);
    idle(5);
    check("twohot_no_frame", 32'(frame_valid), 32'h0);
    push(32'h7654321C, 8'h00, 8'h00, 1'b0);
    strobe(0, glyph[4'hC], 4);
    idle(3);
    check("onehot_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_rx.md
Name: seg7_scan_rx

Overview:
- Receiving end of the 7-segment display interface. Watches a time-multiplexed, active-low segment/anode bus and turns each segment pattern back into a hex nibble.
- Applies a stability filter so switching glitches are not captured. Assembles one frame of NDIG digits and hands it off with a valid/ready handshake.
- Used as a display loopback checker and as a bridge from the display bus back into a register.

Parameters:
- NDIG, 8, number of multiplexed digits (anode lines).
- STABLE, 4, consecutive identical samples needed before a digit is captured (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- an_n  input  NDIG  active-low one-hot digit select. Same clock domain as clk.
- seg_n  input  7  active-low segments: bit0=a … bit6=g.
- digits  output  4*NDIG  decoded nibbles. Digit i is at [4i+3:4i].
- blank  output  NDIG  digit i pattern was all-off (7'b1111111).
- err  output  NDIG  digit i pattern was not a legal hex glyph.
- overrun  output  1  at least one complete frame was dropped while the current frame was held.
- frame_valid  output  1  digits/blank/err hold a complete frame.
- frame_ready  input  1  consumer accepts the frame.

Behaviour:
- Reset (async assert, sync deassert on clk): digits=0, blank=0, err=0, overrun=0, frame_valid=0. Internal state: seen=0, shadow=0, run counter=0, state=COLLECT.
- Sample select:
  - Legal only when exactly one an_n bit is 0.
  - Zero or multiple active bits: no capture, and the run counter clears.
- Run counter:
  - Counts consecutive cycles in which the {an_n, seg_n} pair is unchanged and legal. It saturates at STABLE.
  - Any change restarts the count at 1 (legal) or 0 (illegal).
- Capture:
  - Happens on the edge where the run reaches STABLE, exactly once per run.
  - The decoded nibble, blank and err are written into shadow entry i, and seen[i] is set.
  - A re-strobe of the same digit later overwrites the shadow entry (last value wins).
- Glyph table (pattern → nibble):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000.
  - 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
  - 1111111 → nibble 0, blank=1, err=0.
  - Any other pattern → nibble 0, blank=0, err=1.
- State machine:
  - COLLECT: when seen is all ones, on the next edge copy shadow to the outputs, set frame_valid=1, clear seen and go to HOLD.
    - A capture on that same edge writes shadow and sets the new seen bit; the cleared seen applies to all other bits.
  - HOLD: outputs are frozen and capture continues into shadow.
    - If seen fills while in HOLD: set overrun=1, clear seen, stay in HOLD.
    - On frame_valid && frame_ready: frame_valid=0 and overrun=0 on the next edge, go to COLLECT.
    - If the handshake and a fill occur in the same cycle, the handshake wins, overrun clears, and the fill is dropped with seen cleared.
- Latency: frame_valid rises 1 cycle after the capture that completes seen.
- Reset mid-scan: everything returns to reset values and partial frames are discarded.

Decomposition:
- seg7_pkg holds:
  - the 16 glyph constants;
  - the BLANK constant 7'b1111111;
  - the segment bit-order definition;
  - the digit record typedef {nibble, blank, err}.
- Sub-module seg7_glyph_dec: combinational 7-bit pattern → {nibble, blank, err}. It is instantiated once on the sampled seg_n.

Test Plan:
1. Reset: hold rst_n=0 mid-traffic → all outputs 0. Release, then idle with an_n=8'hFF → frame_valid stays 0.
2. Scan digits 0..7 with glyphs 1..8, 4 cycles each, frame_ready=1 → one frame_valid pulse with digits=32'h87654321, blank=0, err=0, overrun=0.
3. Glitch filter: digit 2 held 3 cycles only, others 4 → no frame. Re-strobe digit 2 for 4 cycles → frame completes.
4. Digit 3 seg_n=7'b1111111 and digit 5 seg_n=7'b0101010 → blank=8'h08, err=8'h20, nibbles 3 and 5 equal 0.
5. Backpressure, frame_ready=0:
   - first scan (glyphs 1..8) → frame_valid=1;
   - second scan with glyph 0 on all digits → overrun=1 and digits still 32'h87654321;
   - raise frame_ready → frame_valid=0 and overrun=0 the next cycle.
6. Two-hot select: an_n=8'hFC with a stable glyph for 10 cycles → nothing captured. Then a single-hot 8'hFE → captured after 4 cycles.
